// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, default bus widths and PPROT bit layout.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_PROT_W = 3;

    // PPROT[0] privileged, PPROT[1] non-secure, PPROT[2] instruction access
    localparam int PPROT_PRIV_BIT  = 0;
    localparam int PPROT_NSEC_BIT  = 1;
    localparam int PPROT_INSTR_BIT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

endpackage

// File: rtl/apb_requester.sv
// APB4 requester: turns a valid/ready command into one SETUP/ACCESS transfer at a time
// and returns a registered response; ACCESS stalls past TIMEOUT_CYCLES are aborted.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [APB_PROT_W-1:0] cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [APB_PROT_W-1:0] pprot,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_req_state_e r_state, w_next;

    logic                  r_write;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_strb;
    logic [APB_PROT_W-1:0] r_prot;
    logic [CNT_W-1:0]      r_wait;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  w_timeout;

    // Abort on the wait state that would push the counter past the limit.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !pready &&
                       (r_wait == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = SETUP;
            end
            SETUP: begin
                psel   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || w_timeout) w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_strb        <= '0;
            r_prot        <= '0;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_write <= cmd_write;
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_write ? cmd_wdata : '0;
                        r_strb  <= cmd_write ? cmd_strb  : '0;
                        r_prot  <= cmd_prot;
                        r_wait  <= '0;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_write ? '0 : prdata;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_wait        <= '0;
                    end else if (w_timeout) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_wait        <= '0;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pwrite      = r_write;
    assign paddr       = r_addr;
    assign pwdata      = r_wdata;
    assign pstrb       = r_strb;
    assign pprot       = r_prot;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: behavioural APB completer with programmable waits/errors/hang,
// scoreboard of expected responses, and APB protocol timing checks.
module tb_apb_requester;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;

    always #5 pclk = ~pclk;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // completer model
    int          cfg_waits;
    logic        cfg_err, cfg_hang;
    int          wcnt;
    logic [31:0] mem [16];

    assign pready  = psel && penable && !cfg_hang && (wcnt == cfg_waits);
    assign pslverr = pready && cfg_err;
    assign prdata  = psel ? mem[paddr[5:2]] : 32'h0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) wcnt <= 0;
        else if (psel && penable && !pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge pclk) begin
        if (pready && pwrite && !cfg_err)
            for (int b = 0; b < 4; b++)
                if (pstrb[b]) mem[paddr[5:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
    end

    // scoreboard
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;
    rsp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p, input bit push,
                         input logic [31:0] e_rd, input logic e_err, input logic e_to);
        rsp_t e;
        @(negedge pclk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        cmd_strb = s; cmd_prot = p;
        if (push) begin
            e.rdata = e_rd; e.err = e_err; e.to = e_to;
            sb_q.push_back(e);
        end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
    endtask

    // exp_en < 0 skips the cycle-count checks (transfer already under way)
    task automatic wait_rsp(input int exp_en, input logic [31:0] e_addr, input logic e_wr,
                            input logic [31:0] e_pwd, input int hold);
        int lat, nsel, nen;
        logic got, stab;
        logic [31:0] s_addr, s_wd, hold_rd;
        logic s_wr;
        logic [3:0] s_strb;
        logic [2:0] s_prot;
        rsp_t e;
        lat = 0; nsel = 0; nen = 0; got = 1'b0; stab = 1'b1;
        s_addr = '0; s_wd = '0; s_wr = 1'b0; s_strb = '0; s_prot = '0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge pclk);
            lat = i;
            if (psel) nsel++;
            if (penable) begin
                if (nen == 0) begin
                    s_addr = paddr; s_wd = pwdata; s_wr = pwrite; s_strb = pstrb; s_prot = pprot;
                end else if (paddr !== s_addr || pwdata !== s_wd || pwrite !== s_wr ||
                             pstrb !== s_strb || pprot !== s_prot) begin
                    stab = 1'b0;
                end
                nen++;
            end
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_arrived", got, 1);
        if (got) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_timeout", rsp_timeout, e.to);
            end
            if (exp_en >= 0) begin
                chk("rsp_latency", lat, exp_en + 2);
                chk("psel_cycles", nsel, exp_en + 1);
                chk("penable_cycles", nen, exp_en);
                chk("apb_stable", stab, 1);
                chk("paddr", s_addr, e_addr);
                chk("pwrite", s_wr, e_wr);
                chk("pwdata", s_wd, e_pwd);
            end
            if (hold > 0) begin
                hold_rd = rsp_rdata;
                cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
                cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF; cmd_prot = 3'b000;
                e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; e.to = 1'b0;
                sb_q.push_back(e);
                for (int i = 0; i < hold; i++) begin
                    @(negedge pclk);
                    chk("hold_cmd_ready", cmd_ready, 0);
                    chk("hold_psel", psel, 0);
                    chk("hold_rsp_valid", rsp_valid, 1);
                    chk("hold_rsp_rdata", rsp_rdata, hold_rd);
                end
            end
            release_rsp();
            chk("rsp_dropped", rsp_valid, 0);
        end
    endtask

    initial begin
        int n;
        logic seen;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        cfg_waits = 0; cfg_err = 1'b0; cfg_hang = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pprot", pprot, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", {rsp_err, rsp_timeout}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        @(negedge pclk); presetn = 1'b1;

        // zero-wait write
        cfg_waits = 0;
        issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 1, 32'h0, 0, 0);
        wait_rsp(1, 32'h10, 1, 32'hDEAD_BEEF, 0);
        // read back with 3 waits: read drives pwdata 0
        cfg_waits = 3;
        issue(0, 32'h10, 32'h1234_5678, 4'hF, 3'b101, 1, 32'hDEAD_BEEF, 0, 0);
        wait_rsp(4, 32'h10, 0, 32'h0, 0);
        // partial strobes
        cfg_waits = 1;
        issue(1, 32'h14, 32'h1122_3344, 4'b0101, 3'b000, 1, 32'h0, 0, 0);
        wait_rsp(2, 32'h14, 1, 32'h1122_3344, 0);
        cfg_waits = 0;
        issue(0, 32'h14, 32'h0, 4'h0, 3'b000, 1, 32'h0022_0044, 0, 0);
        wait_rsp(1, 32'h14, 0, 32'h0, 0);
        // slave errors on read and write
        cfg_err = 1'b1;
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'hDEAD_BEEF, 1, 0);
        wait_rsp(1, 32'h10, 0, 32'h0, 0);
        issue(1, 32'h10, 32'h0BAD_0BAD, 4'hF, 3'b000, 1, 32'h0, 1, 0);
        wait_rsp(1, 32'h10, 1, 32'h0BAD_0BAD, 0);
        cfg_err = 1'b0;
        // timeout
        cfg_hang = 1'b1;
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'h0, 1, 1);
        wait_rsp(TO + 1, 32'h10, 0, 32'h0, 0);
        cfg_hang = 1'b0;
        // recovery after timeout
        cfg_waits = 2;
        issue(1, 32'h18, 32'hCAFE_F00D, 4'hF, 3'b000, 1, 32'h0, 0, 0);
        wait_rsp(3, 32'h18, 1, 32'hCAFE_F00D, 0);
        cfg_waits = 0;
        issue(0, 32'h18, 32'h0, 4'h0, 3'b000, 1, 32'hCAFE_F00D, 0, 0);
        wait_rsp(1, 32'h18, 0, 32'h0, 0);

        // backpressure on response with a command waiting
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'hDEAD_BEEF, 0, 0);
        wait_rsp(1, 32'h10, 0, 32'h0, 5);
        n = 0;
        for (int i = 1; i <= 3 && n == 0; i++) begin
            @(negedge pclk);
            if (psel) n = i;
        end
        chk("setup_after_release", (n >= 1 && n <= 2), 1);
        cmd_valid = 1'b0;
        wait_rsp(-1, 32'h0, 0, 32'h0, 0);

        // reset during ACCESS
        cfg_hang = 1'b1;
        issue(1, 32'h20, 32'h1234_5678, 4'hF, 3'b000, 0, 32'h0, 0, 0);
        @(negedge pclk);
        @(negedge pclk);
        chk("pre_rst_penable", penable, 1);
        #2 presetn = 1'b0;
        #1;
        chk("async_psel", psel, 0);
        chk("async_penable", penable, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1; cfg_hang = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge pclk);
            if (rsp_valid || psel) seen = 1'b1;
        end
        chk("no_rsp_after_rst", seen, 0);
        chk("cmd_ready_after_rst", cmd_ready, 1);
        cfg_waits = 1;
        issue(0, 32'h10, 32'h0, 4'h0, 3'b000, 1, 32'hDEAD_BEEF, 0, 0);
        wait_rsp(2, 32'h10, 0, 32'h0, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
